// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous memory port (1-cycle read latency) between the
// instruction-fetch requester and the load/store requester. One requester is
// granted at a time. Its request is captured, replayed to memory for one
// cycle, and completed with a one-cycle valid pulse.
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   iIfReq/iIfAddr        : fetch request (held until oIfValid) and address
//   oIfRData/oIfValid     : fetch read data and completion pulse
//   iDReq/iDWe/iDAddr     : data request, 1=store/0=load, address
//   iDWData/iDBe          : store data and byte enables
//   oDRData/oDValid       : load data and completion pulse (loads and stores)
//   oMemEn/oMemWe         : memory strobe and write enable (ISSUE only)
//   oMemAddr/oMemWData/
//   oMemBe                : captured address/data/byte enables to memory
//   iMemRData             : memory read data, valid the cycle after a read
//   oBusy                 : high while a transaction is in flight
//   oGrant                : current/last owner, 0 = fetch, 1 = data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  iIfReq,
   input  logic [ADDR_W-1:0]     iIfAddr,
   output logic [DATA_W-1:0]     oIfRData,
   output logic                  oIfValid,
   input  logic                  iDReq,
   input  logic                  iDWe,
   input  logic [ADDR_W-1:0]     iDAddr,
   input  logic [DATA_W-1:0]     iDWData,
   input  logic [DATA_W/8-1:0]   iDBe,
   output logic [DATA_W-1:0]     oDRData,
   output logic                  oDValid,
   output logic                  oMemEn,
   output logic                  oMemWe,
   output logic [ADDR_W-1:0]     oMemAddr,
   output logic [DATA_W-1:0]     oMemWData,
   output logic [DATA_W/8-1:0]   oMemBe,
   input  logic [DATA_W-1:0]     iMemRData,
   output logic                  oBusy,
   output logic                  oGrant
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_owner;    // 0 = fetch, 1 = data
   logic                r_last;     // owner of the last completed transaction
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;

   logic                w_grant_vld;
   logic                w_grant_d;

   // Next-state, grant decision and outputs
   always_comb begin
      w_state_nxt = r_state;
      w_grant_vld = 1'b0;
      w_grant_d   = r_owner;
      oMemEn      = 1'b0;
      oMemWe      = 1'b0;
      oIfValid    = 1'b0;
      oDValid     = 1'b0;
      oBusy       = 1'b1;

      case (r_state)
         IDLE: begin
            oBusy = 1'b0;
            if (iIfReq && iDReq) begin
               // Tie: the requester that did not win last time gets the port.
               w_grant_vld = 1'b1;
               w_grant_d   = ~r_last;
            end else if (iIfReq) begin
               w_grant_vld = 1'b1;
               w_grant_d   = 1'b0;
            end else if (iDReq) begin
               w_grant_vld = 1'b1;
               w_grant_d   = 1'b1;
            end
            if (w_grant_vld) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            oMemEn      = 1'b1;
            oMemWe      = r_we;
            w_state_nxt = DONE;
         end
         DONE: begin
            // Requests are not looked at here; they are re-evaluated in IDLE.
            oIfValid    = ~r_owner;
            oDValid     = r_owner;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register and captured request
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;            // fetch wins the first tie
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_be    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_vld) begin
            // Fields stay frozen until the next grant, so requester changes
            // after this edge never reach the memory port.
            r_owner <= w_grant_d;
            r_addr  <= w_grant_d ? iDAddr : iIfAddr;
            r_we    <= w_grant_d & iDWe;
            r_wdata <= w_grant_d ? iDWData : '0;
            r_be    <= w_grant_d ? iDBe : {BE_W{1'b1}};
         end
         if (r_state == DONE) begin
            r_last <= r_owner;
         end
      end
   end

   assign oMemAddr  = r_addr;
   assign oMemWData = r_wdata;
   assign oMemBe    = r_be;
   assign oGrant    = r_owner;

   // Read data is a straight pass-through; only the valid pulses qualify it.
   assign oIfRData  = iMemRData;
   assign oDRData   = iMemRData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                clock = 1'b0;
   logic                reset;
   logic                iIfReq;
   logic [ADDR_W-1:0]   iIfAddr;
   logic [DATA_W-1:0]   oIfRData;
   logic                oIfValid;
   logic                iDReq;
   logic                iDWe;
   logic [ADDR_W-1:0]   iDAddr;
   logic [DATA_W-1:0]   iDWData;
   logic [3:0]          iDBe;
   logic [DATA_W-1:0]   oDRData;
   logic                oDValid;
   logic                oMemEn;
   logic                oMemWe;
   logic [ADDR_W-1:0]   oMemAddr;
   logic [DATA_W-1:0]   oMemWData;
   logic [3:0]          oMemBe;
   logic [DATA_W-1:0]   iMemRData = '0;
   logic                oBusy;
   logic                oGrant;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        owner;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .iIfReq    (iIfReq),
      .iIfAddr   (iIfAddr),
      .oIfRData  (oIfRData),
      .oIfValid  (oIfValid),
      .iDReq     (iDReq),
      .iDWe      (iDWe),
      .iDAddr    (iDAddr),
      .iDWData   (iDWData),
      .iDBe      (iDBe),
      .oDRData   (oDRData),
      .oDValid   (oDValid),
      .oMemEn    (oMemEn),
      .oMemWe    (oMemWe),
      .oMemAddr  (oMemAddr),
      .oMemWData (oMemWData),
      .oMemBe    (oMemBe),
      .iMemRData (iMemRData),
      .oBusy     (oBusy),
      .oGrant    (oGrant)
   );

   always #5 clock = ~clock;

   // Read-only memory contents; address 0x10 holds the test instruction.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0050_0093;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous memory: data appears the cycle after a read strobe.
   always @(posedge clock) begin
      if (oMemEn && !oMemWe) iMemRData <= mem_rd(oMemAddr);
   end

   function automatic exp_t mk_fetch(input logic [31:0] a);
      exp_t e;
      e.owner = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0;
      e.be = 4'hF; e.rdata = mem_rd(a);
      return e;
   endfunction

   function automatic exp_t mk_data(input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      e.owner = 1'b1; e.we = we; e.addr = a; e.wdata = wd;
      e.be = we ? be : be; e.rdata = mem_rd(a);
      return e;
   endfunction

   // Scoreboard monitor: memory accesses and completions against queued items.
   always @(negedge clock) begin
      if (!reset) begin
         if (oMemEn) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL issue_unexpected: got addr=%h we=%b, expected no access", oMemAddr, oMemWe);
            end else if (oMemWe !== sb[0].we || oMemAddr !== sb[0].addr || oMemBe !== sb[0].be ||
                         (sb[0].we && oMemWData !== sb[0].wdata)) begin
               n_fail++;
               $display("[TB] FAIL issue_fields: got we=%b addr=%h be=%b wd=%h, expected we=%b addr=%h be=%b wd=%h",
                        oMemWe, oMemAddr, oMemBe, oMemWData, sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata);
            end
         end
         if (oIfValid || oDValid) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL done_unexpected: got ifv=%b dv=%b, expected no completion", oIfValid, oDValid);
            end else begin
               if (oIfValid !== ~sb[0].owner || oDValid !== sb[0].owner || oGrant !== sb[0].owner ||
                   (!sb[0].owner && oIfRData !== sb[0].rdata) ||
                   (sb[0].owner && !sb[0].we && oDRData !== sb[0].rdata)) begin
                  n_fail++;
                  $display("[TB] FAIL done_fields: got ifv=%b dv=%b grant=%b ifrd=%h drd=%h, expected owner=%b rdata=%h",
                           oIfValid, oDValid, oGrant, oIfRData, oDRData, sb[0].owner, sb[0].rdata);
               end
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_tests++;
      if ({oMemEn, oMemWe, oIfValid, oDValid, oBusy, oGrant} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got en/we/ifv/dv/busy/grant=%b, expected 000000",
                  {oMemEn, oMemWe, oIfValid, oDValid, oBusy, oGrant});
      end
      n_tests++;
      if (oMemAddr !== 32'h0 || oMemWData !== 32'h0 || oMemBe !== 4'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_captured: got addr=%h wd=%h be=%b, expected zeros", oMemAddr, oMemWData, oMemBe);
      end
      next_cycle();
      reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_fetch_read();
      logic d_seen = 1'b0;
      sb.push_back(mk_fetch(32'h10));
      iIfAddr = 32'h10;
      iIfReq  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (oDValid) d_seen = 1'b1;
         if (c == 1) begin
            n_tests++;
            if (oMemEn !== 1'b1 || oMemWe !== 1'b0 || oMemAddr !== 32'h10 || oMemBe !== 4'hF) begin
               n_fail++;
               $display("[TB] FAIL fetch_issue: got en=%b we=%b addr=%h be=%b, expected 1 0 00000010 1111",
                        oMemEn, oMemWe, oMemAddr, oMemBe);
            end
         end
         if (c == 2) begin
            n_tests++;
            if (oIfValid !== 1'b1 || oIfRData !== 32'h0050_0093) begin
               n_fail++;
               $display("[TB] FAIL fetch_done: got ifv=%b rdata=%h, expected 1 00500093", oIfValid, oIfRData);
            end
            iIfReq = 1'b0;
         end
         next_cycle();
      end
      n_tests++;
      if (d_seen !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fetch_no_dvalid: got oDValid seen=%b, expected 0", d_seen);
      end
   endtask

   task automatic test_store();
      logic if_seen = 1'b0;
      sb.push_back(mk_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011));
      iDWe = 1'b1; iDAddr = 32'h2000; iDWData = 32'hDEAD_BEEF; iDBe = 4'b0011;
      iDReq = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (oIfValid) if_seen = 1'b1;
         if (c == 1) begin
            n_tests++;
            if (oMemEn !== 1'b1 || oMemWe !== 1'b1 || oMemBe !== 4'b0011 || oMemWData !== 32'hDEAD_BEEF) begin
               n_fail++;
               $display("[TB] FAIL store_issue: got en=%b we=%b be=%b wd=%h, expected 1 1 0011 deadbeef",
                        oMemEn, oMemWe, oMemBe, oMemWData);
            end
         end
         if (c == 2) begin
            n_tests++;
            if (oDValid !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL store_done: got oDValid=%b, expected 1", oDValid);
            end
            iDReq = 1'b0;
            iDWe  = 1'b0;
         end
         next_cycle();
      end
      n_tests++;
      if (if_seen !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL store_no_ifvalid: got oIfValid seen=%b, expected 0", if_seen);
      end
   endtask

   task automatic test_tie();
      sb.push_back(mk_fetch(32'h40));
      sb.push_back(mk_data(1'b0, 32'h80, 32'h0, 4'hF));
      sb.push_back(mk_fetch(32'h40));
      iIfAddr = 32'h40; iDAddr = 32'h80; iDWe = 1'b0; iDBe = 4'hF;
      iIfReq = 1'b1; iDReq = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(negedge clock);
         if (c == 2 || c == 5 || c == 8) begin
            logic exp_d;
            exp_d = (c == 5);
            n_tests++;
            if (oIfValid !== ~exp_d || oDValid !== exp_d || oGrant !== exp_d) begin
               n_fail++;
               $display("[TB] FAIL tie_order_c%0d: got ifv=%b dv=%b grant=%b, expected owner=%b",
                        c, oIfValid, oDValid, oGrant, exp_d);
            end
         end
         if (c == 8) begin
            iIfReq = 1'b0;
            iDReq  = 1'b0;
         end
         next_cycle();
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL tie_drain: got %0d pending, expected 0", sb.size());
      end
   endtask

   task automatic test_frozen_capture();
      sb.push_back(mk_fetch(32'h10));
      iIfAddr = 32'h10;
      iIfReq  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            iIfAddr = 32'h20;
            iIfReq  = 1'b0;
         end
         @(negedge clock);
         if (c == 1) begin
            n_tests++;
            if (oMemEn !== 1'b1 || oMemAddr !== 32'h10) begin
               n_fail++;
               $display("[TB] FAIL frozen_addr: got en=%b addr=%h, expected 1 00000010", oMemEn, oMemAddr);
            end
         end
         if (c == 2) begin
            n_tests++;
            if (oIfValid !== 1'b1 || oIfRData !== 32'h0050_0093) begin
               n_fail++;
               $display("[TB] FAIL frozen_done: got ifv=%b rdata=%h, expected 1 00500093", oIfValid, oIfRData);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      sb.push_back(mk_fetch(32'h30));
      iIfAddr = 32'h30;
      iIfReq  = 1'b1;
      next_cycle();
      reset  = 1'b1;
      iIfReq = 1'b0;
      next_cycle();
      reset = 1'b0;
      sb.delete();
      @(negedge clock);
      n_tests++;
      if (oMemEn !== 1'b0 || oBusy !== 1'b0 || oIfValid !== 1'b0 || oDValid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_outputs: got en=%b busy=%b ifv=%b dv=%b, expected 0 0 0 0",
                  oMemEn, oBusy, oIfValid, oDValid);
      end
      next_cycle();
      sb.push_back(mk_fetch(32'h50));
      iIfAddr = 32'h50; iDAddr = 32'h60; iDWe = 1'b0; iDBe = 4'hF;
      iIfReq = 1'b1; iDReq = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (c == 2) begin
            n_tests++;
            if (oIfValid !== 1'b1 || oGrant !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL reset_mid_tie: got ifv=%b grant=%b, expected 1 0", oIfValid, oGrant);
            end
            iIfReq = 1'b0;
            iDReq  = 1'b0;
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      sb.push_back(mk_data(1'b0, 32'h0, 32'h0, 4'hF));
      sb.push_back(mk_data(1'b0, 32'h4, 32'h0, 4'hF));
      sb.push_back(mk_data(1'b0, 32'h8, 32'h0, 4'hF));
      iDWe = 1'b0; iDAddr = 32'h0; iDBe = 4'hF;
      iDReq = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(negedge clock);
         if (c <= 8) begin
            n_tests++;
            if (oMemEn !== (c % 3 == 1) || oDValid !== (c % 3 == 2)) begin
               n_fail++;
               $display("[TB] FAIL b2b_timing_c%0d: got en=%b dv=%b, expected en=%b dv=%b",
                        c, oMemEn, oDValid, (c % 3 == 1), (c % 3 == 2));
            end
         end
         if (c == 2) iDAddr = 32'h4;
         if (c == 5) iDAddr = 32'h8;
         if (c == 8) iDReq = 1'b0;
         next_cycle();
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_drain: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      iIfReq = 1'b0; iIfAddr = '0;
      iDReq = 1'b0; iDWe = 1'b0; iDAddr = '0; iDWData = '0; iDBe = '0;
      test_reset();
      test_fetch_read();
      test_store();
      test_tie();
      test_frozen_capture();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between the instruction-fetch path and the load/store path of the RISC-V datapath. It is used when the design moves to a unified instruction/data memory. It grants one requester at a time, replays the captured request to memory, and returns read data or a write acknowledge. The block sits between the datapath's fetch/data request interfaces and the memory macro (1-cycle synchronous read).

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and of the memory port
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- iIfReq  in  1  fetch request; held high until oIfValid
- iIfAddr  in  ADDR_W  fetch address
- oIfRData  out  DATA_W  fetch read data, meaningful only while oIfValid
- oIfValid  out  1  one-cycle completion pulse for fetch
- iDReq  in  1  data request; held high until oDValid
- iDWe  in  1  1 = store, 0 = load
- iDAddr  in  ADDR_W  data address
- iDWData  in  DATA_W  store data
- iDBe  in  DATA_W/8  store byte enables
- oDRData  out  DATA_W  load data, meaningful only while oDValid on a load
- oDValid  out  1  one-cycle completion pulse for load or store
- oMemEn  out  1  memory access strobe
- oMemWe  out  1  memory write enable
- oMemAddr  out  ADDR_W  memory address
- oMemWData  out  DATA_W  memory write data
- oMemBe  out  DATA_W/8  memory byte enables
- iMemRData  in  DATA_W  memory read data, valid the cycle after an oMemEn read
- oBusy  out  1  high whenever state != IDLE
- oGrant  out  1  current/last owner: 0 = fetch, 1 = data

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - no request -> stay in IDLE.
  - only one request high -> grant it.
  - both high -> grant the requester not recorded in lastGrant (round-robin).
  - On grant, capture owner, addr, we, wdata and be, then go to ISSUE. A fetch captures we=0 and be=all ones.
- ISSUE: oMemEn=1; oMemWe=captured we; oMemAddr/oMemWData/oMemBe come from the captured copy. Next state is DONE.
- DONE:
  - The owner's valid is 1. Its rdata is iMemRData, passed through combinationally; the non-owner's valid is 0.
  - Set lastGrant=owner and go to IDLE.
  - Requests are ignored in DONE.
- Captured fields are frozen from the grant edge until IDLE. Requester input changes after the grant, including dropping req, do not affect or abort the transaction.
- A request still high in the IDLE cycle after its valid pulse starts a new transaction.
- A store also completes with a valid pulse; oDRData content is don't-care on stores.
- oMemEn and oMemWe are 0 outside ISSUE. oMemAddr/oMemWData/oMemBe hold the captured values.
- oIfRData and oDRData both carry iMemRData at all times; only the valid pulses qualify them.

## Timing
- Reset values: state=IDLE; lastGrant=1, so fetch wins the first tie; oGrant=0; captured fields=0.
- Reset values of outputs: oMemEn=0, oMemWe=0, oIfValid=0, oDValid=0, oBusy=0.
- Latency: request sampled in IDLE at cycle N, oMemEn in cycle N+1, valid pulse in cycle N+2.
- Throughput: one access per 3 cycles per arbiter; a continuously requesting pair alternates F, D, F, D.
- A lone requester is never blocked. A starved requester waits at most one transaction (3 cycles) after the other's grant.
- Reset asserted in any state:
  - next cycle: IDLE, no valid pulse, oMemEn=0, lastGrant=1.
  - any in-flight transaction is dropped; the requester must re-request.
- Simultaneous request and completion: requests seen during DONE are only evaluated in the following IDLE cycle.

## Test plan
- Fetch read: iIfReq=1, iIfAddr=0x00000010, memory returns 0x00500093. Required: cycle 1 oMemEn=1, oMemWe=0, oMemAddr=0x10, oMemBe=1111; cycle 2 oIfValid=1 with oIfRData=0x00500093; oDValid stays 0.
- Store: iDReq=1, iDWe=1, iDAddr=0x00002000, iDWData=0xDEADBEEF, iDBe=0011. Required: cycle 1 oMemWe=1, oMemBe=0011, oMemWData=0xDEADBEEF; cycle 2 oDValid=1; oIfValid never 1.
- Tie after reset: both requests held high for 9 cycles. Required: valid pulses in cycles 2, 5, 8 go to fetch, data, fetch; oGrant follows the same order.
- Frozen capture: after the fetch grant edge, change iIfAddr from 0x10 to 0x20. Required: oMemAddr=0x10 in ISSUE.
- Reset mid-operation: assert reset in the ISSUE cycle. Required: next cycle oMemEn=0, oBusy=0, no valid pulse; a subsequent tie is granted to fetch.
- Back-to-back single requester: iDReq held high with loads to 0x0, 0x4, 0x8. Required: oMemEn in cycles 1, 4, 7 and oDValid in cycles 2, 5, 8 with the matching addresses.
